clkdiv_sched: RTL

- Run/stop and reconfiguration controller around a programmable terminal-count divider.
- Sequences the divider: continuous or N-tick burst runs, start/stop at period boundaries, handshaked terminal-count updates applied only at safe wrap points.
- Outputs a one-cycle `tick` enable and a toggled `clk_div` for downstream PWM/mixer logic in the same clock domain.

---
 rtl/clkdiv_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clkdiv_sched.sv
// Run/stop sequencer around a programmable terminal-count divider.
// Produces a one-cycle tick per period and a toggled clk_div, with handshaked TC updates.
module clkdiv_sched #(
    parameter int CNT_W      = 16,
    parameter int DEFAULT_TC = 3,
    parameter int BURST_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_tc,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               stop,
    output logic               tick,
    output logic               clk_div,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   TC_RST  = CNT_W'(DEFAULT_TC);
    localparam logic [BURST_W-1:0] REM_ONE = BURST_W'(1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [CNT_W-1:0]   active_tc_q, active_tc_d;
    logic [CNT_W-1:0]   shadow_q,    shadow_d;
    logic               pending_q,   pending_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               tick_q,      tick_d;
    logic               done_q,      done_d;
    logic               clk_div_q,   clk_div_d;

    logic cap;
    logic wrap;
    logic final_wrap;

    assign cfg_ready = ~pending_q;
    assign busy      = (state_q != S_IDLE);
    assign tick      = tick_q;
    assign done      = done_q;
    assign clk_div   = clk_div_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        active_tc_d = active_tc_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        clk_div_d   = clk_div_q;

        cap  = cfg_valid & ~pending_q;
        wrap = (state_q != S_IDLE) && (count_q == active_tc_q);
        // A wrap ends the run if a stop is already latched, arrives now, or the burst is exhausted.
        final_wrap = (state_q == S_STOPPING) || stop || (remaining_q == REM_ONE);

        case (state_q)
            S_IDLE: begin
                clk_div_d = 1'b0;
                count_d   = '0;
                if (pending_q) begin
                    active_tc_d = shadow_q;
                    pending_d   = 1'b0;
                end else if (cap) begin
                    shadow_d  = cfg_tc;
                    pending_d = 1'b1;
                end
                if (start) begin
                    state_d     = S_RUN;
                    count_d     = '0;
                    remaining_d = burst_len;
                end
            end

            S_RUN, S_STOPPING: begin
                if (wrap) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    // Pending config lands here; a capture on this edge waits for the next wrap.
                    if (pending_q) begin
                        active_tc_d = shadow_q;
                        pending_d   = 1'b0;
                    end else if (cap) begin
                        shadow_d  = cfg_tc;
                        pending_d = 1'b1;
                    end
                    if (final_wrap) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        clk_div_d = 1'b0;
                    end else begin
                        clk_div_d = ~clk_div_q;
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - REM_ONE;
                        end
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                    if (cap) begin
                        shadow_d  = cfg_tc;
                        pending_d = 1'b1;
                    end
                    if ((state_q == S_RUN) && stop) begin
                        state_d = S_STOPPING;
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                count_d   = '0;
                clk_div_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            active_tc_q <= TC_RST;
            pending_q   <= 1'b0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            clk_div_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            active_tc_q <= active_tc_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            clk_div_q   <= clk_div_d;
        end
        // Shadow holds data only; it is meaningless until pending is set.
        shadow_q <= shadow_d;
    end

endmodule
